// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Valid/ready record channel carrying one PWM period measurement.
//   Set WIDTH to the same value as the WIDTH of the pwm_capture that drives it.
//
//   m_valid  producer -> consumer  a measurement record is available
//   m_ready  consumer -> producer  the record is accepted when m_valid && m_ready
//   m_t_on   producer -> consumer  high time, in clock cycles
//   m_t_off  producer -> consumer  low time, in clock cycles
//   m_sat    producer -> consumer  m_t_on or m_t_off hit the saturation value
//
//   master: the measuring block. slave: the consumer.
interface pwm_capture_if #(
  parameter int WIDTH = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_t_on;
  logic [WIDTH-1:0] m_t_off;
  logic             m_sat;

  modport master (
    output m_valid,
    output m_t_on,
    output m_t_off,
    output m_sat,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_t_on,
    input  m_t_off,
    input  m_sat,
    output m_ready
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures the high and low time of each complete period on a PWM line
//   and hands every period out as one record on a valid/ready channel.
//   The partial period in progress at reset release is never reported.
//   Durations saturate at 2^WIDTH-1, and a phase that reaches that count
//   raises stuck.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        synchronous active-low reset
//     pwm_in       PWM line, already synchronous to clk
//     m            record channel (master side): m_valid, m_ready,
//                  m_t_on, m_t_off, m_sat
//     stuck        current phase has reached the saturation count
//     overrun      sticky: a record was dropped because the output
//                  register was still occupied
//     clr_overrun  single-cycle pulse that clears overrun
module pwm_capture #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_in,
  pwm_capture_if.master   m,
  output logic            stuck,
  output logic            overrun,
  input  logic            clr_overrun
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic             pwm_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] on_len;
  logic [WIDTH-1:0] on_len_d;
  logic             on_sat;
  logic             on_sat_d;

  logic             rise;
  logic             fall;

  logic             emit;
  logic [WIDTH-1:0] rec_t_on;
  logic [WIDTH-1:0] rec_t_off;
  logic             rec_sat;
  logic             drop;

  // Counter increment that sticks at MAX instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
    return (x == MAX) ? MAX : x + ONE;
  endfunction

  // Edges are taken from the live input against last cycle's sample, so a
  // transition is acted on in the same cycle it is first seen.
  assign rise = pwm_in & ~pwm_q;
  assign fall = ~pwm_in & pwm_q;

  // The edge register is loaded from the live input even during reset, so
  // a level held across reset release is not mistaken for an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= SYNC;
      pwm_q  <= pwm_in;
      cnt    <= '0;
      on_len <= '0;
      on_sat <= 1'b0;
    end else begin
      state  <= state_d;
      pwm_q  <= pwm_in;
      cnt    <= cnt_d;
      on_len <= on_len_d;
      on_sat <= on_sat_d;
    end
  end

  // SYNC waits for the first rise so that measurement starts on a clean
  // period boundary. The high time is parked in on_len at the fall, and the
  // closing rise emits the record built from on_len and the low count.
  // A fresh phase starts at 1 because the edge cycle itself already carries
  // the new level.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    on_len_d  = on_len;
    on_sat_d  = on_sat;
    emit      = 1'b0;
    rec_t_on  = on_len;
    rec_t_off = cnt;
    rec_sat   = on_sat | (cnt == MAX);

    case (state)
      SYNC: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          on_len_d = cnt;
          on_sat_d = (cnt == MAX);
          cnt_d    = ONE;
          state_d  = LOW;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end
      LOW: begin
        if (rise) begin
          emit    = 1'b1;
          cnt_d   = ONE;
          state_d = HIGH;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end
      default: begin
        state_d = SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  // A record is dropped only when the output register still holds an
  // unaccepted record; a handshake in the same cycle frees the slot.
  assign drop = emit & m.m_valid & ~m.m_ready;

  // Single-entry output register. A new record may replace an accepted one
  // in the same cycle, so a ready consumer sees no bubble. A drop wins over
  // clr_overrun so that a loss is never silently cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m.m_valid <= 1'b0;
      m.m_t_on  <= '0;
      m.m_t_off <= '0;
      m.m_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end

      if (emit && !drop) begin
        m.m_valid <= 1'b1;
        m.m_t_on  <= rec_t_on;
        m.m_t_off <= rec_t_off;
        m.m_sat   <= rec_sat;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end

  // stuck follows the live counter; it drops on the next edge when the
  // counter reloads to 1.
  assign stuck = (state != SYNC) && (cnt == MAX);

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Self-checking bench for pwm_capture. A WIDTH=8 instance is checked every
//   cycle against a run-length reference model plus table vectors and
//   hand-written corner sequences; a WIDTH=4 instance covers saturation.
module tb_pwm_capture;

  localparam int MAX8 = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic rst_n       = 1'b0;
  logic pwm_in      = 1'b0;
  logic clr_overrun = 1'b0;
  logic stuck;
  logic overrun;
  pwm_capture_if #(.WIDTH(8)) bus ();

  pwm_capture #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .m           (bus.master),
    .stuck       (stuck),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // WIDTH=4 instance
  logic rst4_n = 1'b0;
  logic pwm4   = 1'b0;
  logic clr4   = 1'b0;
  logic stuck4;
  logic overrun4;
  pwm_capture_if #(.WIDTH(4)) bus4 ();

  pwm_capture #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst4_n),
    .pwm_in      (pwm4),
    .m           (bus4.master),
    .stuck       (stuck4),
    .overrun     (overrun4),
    .clr_overrun (clr4)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: run lengths of the sampled line, unbounded, clipped to
  // MAX only when a record is formed.
  int m_armed, m_in_high, m_prev;
  int m_high, m_low, m_on;
  int mv, mt_on, mt_off, msat, movr;

  typedef struct {
    int hi;
    int lo;
    int e_on;
    int e_off;
    int e_sat;
  } vec_t;

  vec_t vecs[9];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int min_max(input int x);
    return (x > MAX8) ? MAX8 : x;
  endfunction

  task automatic model_step(input int r, input int in, input int rdy, input int clr);
    int rise, fall, emit, drop, r_on, r_off, r_sat;
    if (r == 0) begin
      m_armed = 0; m_in_high = 0; m_prev = in;
      m_high = 0; m_low = 0; m_on = 0;
      mv = 0; mt_on = 0; mt_off = 0; msat = 0; movr = 0;
      return;
    end
    rise = (in == 1 && m_prev == 0) ? 1 : 0;
    fall = (in == 0 && m_prev == 1) ? 1 : 0;
    emit = 0; r_on = 0; r_off = 0; r_sat = 0;
    if (m_armed == 0) begin
      if (rise == 1) begin
        m_armed = 1; m_in_high = 1; m_high = 1;
      end
    end else if (m_in_high == 1) begin
      if (fall == 1) begin
        m_on = m_high; m_in_high = 0; m_low = 1;
      end else begin
        m_high++;
      end
    end else begin
      if (rise == 1) begin
        emit  = 1;
        r_on  = min_max(m_on);
        r_off = min_max(m_low);
        r_sat = (m_on >= MAX8 || m_low >= MAX8) ? 1 : 0;
        m_in_high = 1; m_high = 1;
      end else begin
        m_low++;
      end
    end
    m_prev = in;
    drop = (emit == 1 && mv == 1 && rdy == 0) ? 1 : 0;
    if (drop == 1) movr = 1;
    else if (clr == 1) movr = 0;
    if (emit == 1 && drop == 0) begin
      mv = 1; mt_on = r_on; mt_off = r_off; msat = r_sat;
    end else if (mv == 1 && rdy == 1) begin
      mv = 0;
    end
  endtask

  function automatic int model_stuck();
    int run;
    run = (m_in_high == 1) ? m_high : m_low;
    return (m_armed == 1 && run >= MAX8) ? 1 : 0;
  endfunction

  // One clock of the WIDTH=8 instance: drive on the falling edge, advance
  // the model at the rising edge, compare just after it.
  task automatic apply_stimulus(input int r, input int p, input int rdy, input int clr);
    @(negedge clk);
    rst_n       = (r != 0);
    pwm_in      = (p != 0);
    bus.m_ready = (rdy != 0);
    clr_overrun = (clr != 0);
    @(posedge clk);
    model_step(r, p, rdy, clr);
    #1;
    check_output("model_valid", 32'(bus.m_valid), mv);
    if (mv == 1) begin
      check_output("model_t_on", 32'(bus.m_t_on), mt_on);
      check_output("model_t_off", 32'(bus.m_t_off), mt_off);
      check_output("model_sat", 32'(bus.m_sat), msat);
    end
    check_output("model_stuck", 32'(stuck), model_stuck());
    check_output("model_overrun", 32'(overrun), movr);
  endtask

  task automatic run_level(input int p, input int n, input int rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1, p, rdy, 0);
  endtask

  task automatic step4(input int r, input int p);
    @(negedge clk);
    rst4_n       = (r != 0);
    pwm4         = (p != 0);
    bus4.m_ready = 1'b1;
    clr4         = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nrec;
    int hi, lo, rdy, clr, rst;

    vecs[0] = '{64, 16, 64, 16, 0};
    vecs[1] = '{1, 1, 1, 1, 0};
    vecs[2] = '{2, 1, 2, 1, 0};
    vecs[3] = '{255, 3, 255, 3, 1};
    vecs[4] = '{300, 2, 255, 2, 1};
    vecs[5] = '{5, 255, 5, 255, 1};
    vecs[6] = '{3, 256, 3, 255, 1};
    vecs[7] = '{254, 254, 254, 254, 0};
    vecs[8] = '{7, 9, 7, 9, 0};

    bus.m_ready  = 1'b1;
    bus4.m_ready = 1'b1;

    // Reset state
    apply_stimulus(0, 0, 1, 0);
    apply_stimulus(0, 0, 1, 0);
    check_output("reset_valid", 32'(bus.m_valid), 0);
    check_output("reset_t_on", 32'(bus.m_t_on), 0);
    check_output("reset_t_off", 32'(bus.m_t_off), 0);
    check_output("reset_sat", 32'(bus.m_sat), 0);
    check_output("reset_stuck", 32'(stuck), 0);
    check_output("reset_overrun", 32'(overrun), 0);

    // Table vectors: record i is emitted on the rise that opens period i+1
    run_level(0, 3, 1);
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].hi; k++) begin
        apply_stimulus(1, 1, 1, 0);
        if (k == 0 && i > 0) begin
          check_output("vec_valid", 32'(bus.m_valid), 1);
          check_output("vec_t_on", 32'(bus.m_t_on), vecs[i-1].e_on);
          check_output("vec_t_off", 32'(bus.m_t_off), vecs[i-1].e_off);
          check_output("vec_sat", 32'(bus.m_sat), vecs[i-1].e_sat);
        end
      end
      run_level(0, vecs[i].lo, 1);
    end
    apply_stimulus(1, 1, 1, 0);
    check_output("vec_valid", 32'(bus.m_valid), 1);
    check_output("vec_t_on", 32'(bus.m_t_on), vecs[8].e_on);
    check_output("vec_t_off", 32'(bus.m_t_off), vecs[8].e_off);
    check_output("vec_sat", 32'(bus.m_sat), vecs[8].e_sat);

    // Duty check: three periods yield exactly two records, each on a rise
    apply_stimulus(0, 0, 1, 0);
    run_level(0, 5, 1);
    nrec = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 64; k++) begin
        apply_stimulus(1, 1, 1, 0);
        if (bus.m_valid) begin
          nrec++;
          check_output("duty_at_rise", k, 0);
          check_output("duty_t_on", 32'(bus.m_t_on), 64);
          check_output("duty_t_off", 32'(bus.m_t_off), 16);
          check_output("duty_sat", 32'(bus.m_sat), 0);
        end
      end
      for (int k = 0; k < 16; k++) begin
        apply_stimulus(1, 0, 1, 0);
        if (bus.m_valid) nrec++;
      end
    end
    check_output("duty_count", nrec, 2);

    // Start-high discard
    apply_stimulus(0, 1, 1, 0);
    nrec = 0;
    for (int k = 0; k < 10; k++) begin apply_stimulus(1, 1, 1, 0); if (bus.m_valid) nrec++; end
    for (int k = 0; k < 7; k++) begin apply_stimulus(1, 0, 1, 0); if (bus.m_valid) nrec++; end
    for (int k = 0; k < 3; k++) begin apply_stimulus(1, 1, 1, 0); if (bus.m_valid) nrec++; end
    for (int k = 0; k < 4; k++) begin apply_stimulus(1, 0, 1, 0); if (bus.m_valid) nrec++; end
    check_output("start_high_none_early", nrec, 0);
    apply_stimulus(1, 1, 1, 0);
    check_output("start_high_valid", 32'(bus.m_valid), 1);
    check_output("start_high_t_on", 32'(bus.m_t_on), 3);
    check_output("start_high_t_off", 32'(bus.m_t_off), 4);

    // Saturation and stuck on the WIDTH=4 instance
    step4(0, 0);
    step4(1, 0);
    step4(1, 0);
    for (int k = 1; k <= 20; k++) begin
      step4(1, 1);
      check_output("sat4_stuck_high", 32'(stuck4), (k >= 15) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      step4(1, 0);
      check_output("sat4_stuck_low", 32'(stuck4), 0);
    end
    step4(1, 1);
    check_output("sat4_valid", 32'(bus4.m_valid), 1);
    check_output("sat4_t_on", 32'(bus4.m_t_on), 15);
    check_output("sat4_t_off", 32'(bus4.m_t_off), 2);
    check_output("sat4_sat", 32'(bus4.m_sat), 1);
    check_output("sat4_overrun", 32'(overrun4), 0);

    // Backpressure and overrun
    apply_stimulus(0, 0, 0, 0);
    run_level(0, 2, 0);
    run_level(1, 2, 0);
    run_level(0, 3, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("bp_first_valid", 32'(bus.m_valid), 1);
    check_output("bp_first_overrun", 32'(overrun), 0);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("bp_drop_overrun", 32'(overrun), 1);
    check_output("bp_held_t_on", 32'(bus.m_t_on), 2);
    check_output("bp_held_t_off", 32'(bus.m_t_off), 3);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 1, 0, 1);
    check_output("bp_clr_during_drop", 32'(overrun), 1);
    apply_stimulus(1, 0, 0, 1);
    check_output("bp_clr_no_drop", 32'(overrun), 0);
    check_output("bp_still_valid", 32'(bus.m_valid), 1);
    check_output("bp_still_t_on", 32'(bus.m_t_on), 2);

    // Back-to-back replacement of an accepted record
    apply_stimulus(0, 0, 1, 0);
    run_level(0, 2, 1);
    run_level(1, 2, 1);
    run_level(0, 1, 1);
    run_level(1, 3, 0);
    run_level(0, 2, 0);
    check_output("b2b_held_valid", 32'(bus.m_valid), 1);
    apply_stimulus(1, 1, 1, 0);
    check_output("b2b_valid", 32'(bus.m_valid), 1);
    check_output("b2b_t_on", 32'(bus.m_t_on), 3);
    check_output("b2b_t_off", 32'(bus.m_t_off), 2);
    for (int p = 0; p < 4; p++) begin
      run_level(1, 1, 1);
      run_level(0, 1, 1);
      apply_stimulus(1, 1, 1, 0);
      check_output("b2b_2_1_valid", 32'(bus.m_valid), 1);
      check_output("b2b_2_1_t_on", 32'(bus.m_t_on), 2);
      check_output("b2b_2_1_t_off", 32'(bus.m_t_off), 1);
    end

    // Reset mid-operation with a held record, an overrun and a HIGH phase
    run_level(1, 1, 0);
    run_level(0, 1, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("midrst_pre_overrun", 32'(overrun), 1);
    apply_stimulus(0, 1, 0, 0);
    check_output("midrst_valid", 32'(bus.m_valid), 0);
    check_output("midrst_stuck", 32'(stuck), 0);
    check_output("midrst_overrun", 32'(overrun), 0);
    nrec = 0;
    for (int k = 0; k < 2; k++) begin apply_stimulus(1, 1, 1, 0); if (bus.m_valid) nrec++; end
    for (int k = 0; k < 2; k++) begin apply_stimulus(1, 0, 1, 0); if (bus.m_valid) nrec++; end
    apply_stimulus(1, 1, 1, 0); if (bus.m_valid) nrec++;
    for (int k = 0; k < 2; k++) begin apply_stimulus(1, 0, 1, 0); if (bus.m_valid) nrec++; end
    check_output("midrst_no_early_record", nrec, 0);
    apply_stimulus(1, 1, 1, 0);
    check_output("midrst_record_valid", 32'(bus.m_valid), 1);
    check_output("midrst_record_t_on", 32'(bus.m_t_on), 1);
    check_output("midrst_record_t_off", 32'(bus.m_t_off), 2);

    // Randomized periods, backpressure, clears and occasional resets
    apply_stimulus(0, 0, 1, 0);
    for (int p = 0; p < 80; p++) begin
      hi = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 12);
      lo = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 300) : $urandom_range(1, 12);
      for (int k = 0; k < hi + lo; k++) begin
        rdy = ($urandom_range(0, 3) != 0) ? 1 : 0;
        clr = ($urandom_range(0, 15) == 0) ? 1 : 0;
        rst = ($urandom_range(0, 599) == 0) ? 0 : 1;
        apply_stimulus(rst, (k < hi) ? 1 : 0, rdy, clr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
